// File: rtl/dmg_lcd_sink_if.sv
// LCD pixel stream from the PPU plus the framebuffer write port it turns into.
// master = stream producer / RAM side, slave = dmg_lcd_sink.
interface dmg_lcd_sink_if #(
   parameter int ADDR_W = 15
);
   logic              lcd_vsync;
   logic              lcd_hsync;
   logic              lcd_pixel;
   logic [1:0]        lcd_color;
   logic              fb_we;
   logic [ADDR_W:0]   fb_addr;
   logic [1:0]        fb_wdata;

   modport master (
      output lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
      input  fb_we, fb_addr, fb_wdata
   );

   modport slave (
      input  lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
      output fb_we, fb_addr, fb_wdata
   );
endinterface

// File: rtl/dmg_lcd_sink.sv
// Receives the PPU LCD stream, rebuilds x/y from the strobes and writes pixels
// into the back bank of a double-buffered framebuffer; flags malformed lines/frames.
module dmg_lcd_sink #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 144,
   parameter int ADDR_W   = 15
) (
   input  logic                clk,
   input  logic                rst,
   dmg_lcd_sink_if.slave       lcd,
   input  logic                err_clr,
   output logic                disp_bank,
   output logic                frame_done,
   output logic [7:0]          frame_count,
   output logic                err_long_line,
   output logic                err_short_line,
   output logic                err_short_frame
);

   localparam int X_W = $clog2(H_PIXELS + 1);
   localparam int Y_W = $clog2(V_LINES + 1);
   localparam logic [X_W-1:0]    X_END     = X_W'(H_PIXELS);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_LINES - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

   typedef enum logic [1:0] {WAIT_VS, ACTIVE, DONE} state_t;

   state_t              state;
   logic                vs_q;
   logic                hs_q;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W-1:0]   line_base;
   logic                we_p1;
   logic [ADDR_W:0]     addr_p1;
   logic [1:0]          wdata_p1;

   logic                vs_rise;
   logic                hs_rise;
   logic                pix_ok;
   logic                pix_long;
   logic [X_W-1:0]      x_pix;
   logic [ADDR_W-1:0]   addr_pix;
   logic                line_close;

   // A pixel in the same cycle as hsync is consumed first, so the line-close
   // decision looks at the position after that pixel.
   always_comb begin
      vs_rise    = lcd.lcd_vsync & ~vs_q;
      hs_rise    = lcd.lcd_hsync & ~hs_q;
      pix_ok     = lcd.lcd_pixel && (x < X_END);
      pix_long   = lcd.lcd_pixel && (x == X_END);
      x_pix      = pix_ok ? x + X_W'(1) : x;
      addr_pix   = pix_ok ? addr + ADDR_W'(1) : addr;
      line_close = hs_rise && (x_pix != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= WAIT_VS;
         vs_q            <= 1'b1;
         hs_q            <= 1'b1;
         x               <= '0;
         y               <= '0;
         addr            <= '0;
         line_base       <= '0;
         we_p1           <= 1'b0;
         addr_p1         <= '0;
         wdata_p1        <= '0;
         disp_bank       <= 1'b0;
         frame_done      <= 1'b0;
         frame_count     <= '0;
         err_long_line   <= 1'b0;
         err_short_line  <= 1'b0;
         err_short_frame <= 1'b0;
      end else begin
         vs_q       <= lcd.lcd_vsync;
         hs_q       <= lcd.lcd_hsync;
         we_p1      <= 1'b0;
         frame_done <= 1'b0;

         // Clear first; any error set later in this block overrides it.
         if (err_clr) begin
            err_long_line   <= 1'b0;
            err_short_line  <= 1'b0;
            err_short_frame <= 1'b0;
         end

         case (state)
            WAIT_VS: begin
               if (vs_rise) begin
                  x         <= '0;
                  y         <= '0;
                  addr      <= '0;
                  line_base <= '0;
                  state     <= ACTIVE;
               end
            end

            ACTIVE: begin
               if (vs_rise) begin
                  err_short_frame <= 1'b1;
                  y               <= '0;
                  line_base       <= '0;
                  if (lcd.lcd_pixel) begin
                     we_p1    <= 1'b1;
                     addr_p1  <= {~disp_bank, {ADDR_W{1'b0}}};
                     wdata_p1 <= lcd.lcd_color;
                     x        <= X_W'(1);
                     addr     <= ADDR_W'(1);
                  end else begin
                     x    <= '0;
                     addr <= '0;
                  end
               end else begin
                  if (pix_ok) begin
                     we_p1    <= 1'b1;
                     addr_p1  <= {~disp_bank, addr};
                     wdata_p1 <= lcd.lcd_color;
                  end
                  if (pix_long) begin
                     err_long_line <= 1'b1;
                  end
                  if (line_close) begin
                     if (x_pix < X_END) begin
                        err_short_line <= 1'b1;
                     end
                     x <= '0;
                     y <= y + Y_W'(1);
                     // Last line: park the address at 0 so it never leaves the bank.
                     if (y == Y_LAST) begin
                        line_base <= '0;
                        addr      <= '0;
                        state     <= DONE;
                     end else begin
                        line_base <= line_base + LINE_STEP;
                        addr      <= line_base + LINE_STEP;
                     end
                  end else begin
                     x    <= x_pix;
                     addr <= addr_pix;
                  end
               end
            end

            DONE: begin
               disp_bank   <= ~disp_bank;
               frame_done  <= 1'b1;
               frame_count <= frame_count + 8'd1;
               state       <= WAIT_VS;
            end

            default: state <= WAIT_VS;
         endcase
      end
   end

   assign lcd.fb_we    = we_p1;
   assign lcd.fb_addr  = addr_p1;
   assign lcd.fb_wdata = wdata_p1;

endmodule

// File: tb/tb_dmg_lcd_sink.sv
// Directed line/frame sequences with random shades, checked against a line-level
// model of where each pixel must land in the framebuffer.
module tb_dmg_lcd_sink;

   localparam int H      = 160;
   localparam int V      = 144;
   localparam int ADDR_W = 15;

   logic       clk;
   logic       rst;
   logic       err_clr;
   logic       disp_bank;
   logic       frame_done;
   logic [7:0] frame_count;
   logic       err_long_line;
   logic       err_short_line;
   logic       err_short_frame;

   dmg_lcd_sink_if #(.ADDR_W(ADDR_W)) bus ();

   dmg_lcd_sink #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(ADDR_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .lcd             (bus.slave),
      .err_clr         (err_clr),
      .disp_bank       (disp_bank),
      .frame_done      (frame_done),
      .frame_count     (frame_count),
      .err_long_line   (err_long_line),
      .err_short_line  (err_short_line),
      .err_short_frame (err_short_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W:0] addr;
      logic [1:0]      data;
   } wr_t;

   wr_t exp_q[$];

   int n_assert = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int done_seen = 0;

   // Reference model state, updated once per line / vsync.
   bit m_active = 0;
   int m_y      = 0;
   bit m_disp   = 0;
   int m_frames = 0;
   int m_done_total = 0;
   int m_wr_total = 0;
   bit m_long = 0, m_short = 0, m_sframe = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (bus.fb_we === 1'b1) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {16'h0, bus.fb_addr}, 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {16'h0, bus.fb_addr}, {16'h0, e.addr});
            chk("wr_data", {30'h0, bus.fb_wdata}, {30'h0, e.data});
         end
      end
      if (frame_done === 1'b1) done_seen++;
   end

   task automatic send_line(input int n, input bit hs_same);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         bus.lcd_pixel = 1'b1;
         bus.lcd_color = 2'($urandom_range(0, 3));
         bus.lcd_hsync = (hs_same && i == n - 1);
         if (m_active) begin
            if (i < H) begin
               e.addr = {~m_disp, 15'(m_y * H + i)};
               e.data = bus.lcd_color;
               exp_q.push_back(e);
               m_wr_total++;
            end else begin
               m_long = 1;
            end
         end
         tick();
      end
      bus.lcd_pixel = 1'b0;
      if (!(hs_same && n > 0)) begin
         bus.lcd_hsync = 1'b1;
         tick();
      end
      bus.lcd_hsync = 1'b0;
      tick();
      if (m_active && n > 0) begin
         if (n < H) m_short = 1;
         m_y++;
         if (m_y == V) begin
            m_active = 0;
            m_frames++;
            m_done_total++;
            m_disp = ~m_disp;
         end
      end
   endtask

   task automatic send_vsync(input bit clr);
      bus.lcd_vsync = 1'b1;
      err_clr = clr;
      if (clr) begin
         m_long = 0; m_short = 0; m_sframe = 0;
      end
      if (m_active) m_sframe = 1;
      m_active = 1;
      m_y = 0;
      tick();
      bus.lcd_vsync = 1'b0;
      err_clr = 1'b0;
      tick();
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      m_long = 0; m_short = 0; m_sframe = 0;
      tick();
   endtask

   task automatic send_frame();
      for (int l = 0; l < V; l++) send_line(H, 1'($urandom_range(0, 1)));
   endtask

   task automatic check_status(input string tag);
      tick();
      tick();
      chk({tag, ".disp_bank"},   {31'h0, disp_bank},       {31'h0, m_disp});
      chk({tag, ".frame_count"}, {24'h0, frame_count},     32'(m_frames % 256));
      chk({tag, ".frame_dones"}, 32'(done_seen),           32'(m_done_total));
      chk({tag, ".err_long"},    {31'h0, err_long_line},   {31'h0, m_long});
      chk({tag, ".err_short"},   {31'h0, err_short_line},  {31'h0, m_short});
      chk({tag, ".err_sframe"},  {31'h0, err_short_frame}, {31'h0, m_sframe});
      chk({tag, ".writes"},      32'(wr_count),            32'(m_wr_total));
      chk({tag, ".pending"},     32'(exp_q.size()),        32'h0);
   endtask

   initial begin
      rst = 1'b1;
      err_clr = 1'b0;
      bus.lcd_vsync = 1'b0;
      bus.lcd_hsync = 1'b0;
      bus.lcd_pixel = 1'b0;
      bus.lcd_color = 2'd0;
      tick(); tick(); tick();
      chk("rst.fb_we",       {31'h0, bus.fb_we},       32'h0);
      chk("rst.fb_addr",     {16'h0, bus.fb_addr},     32'h0);
      chk("rst.fb_wdata",    {30'h0, bus.fb_wdata},    32'h0);
      chk("rst.disp_bank",   {31'h0, disp_bank},       32'h0);
      chk("rst.frame_done",  {31'h0, frame_done},      32'h0);
      chk("rst.frame_count", {24'h0, frame_count},     32'h0);
      chk("rst.err_long",    {31'h0, err_long_line},   32'h0);
      chk("rst.err_short",   {31'h0, err_short_line},  32'h0);
      chk("rst.err_sframe",  {31'h0, err_short_frame}, 32'h0);
      rst = 1'b0;
      tick();

      // Stream activity before any vsync must not reach the framebuffer.
      send_line(20, 1'b0);
      send_line(5, 1'b1);
      check_status("pre_vsync");

      // Frame 1: a blank line, then a clean frame into bank 1.
      send_vsync(1'b0);
      send_line(0, 1'b0);
      send_frame();
      check_status("frame1");

      // Malformed frame into bank 0: long line 0, short line 5, vsync after 10 lines.
      send_vsync(1'b0);
      send_line(H + 1, 1'b0);
      for (int l = 1; l < 5; l++) send_line(H, 1'($urandom_range(0, 1)));
      send_line(100, 1'($urandom_range(0, 1)));
      for (int l = 6; l < 10; l++) send_line(H, 1'($urandom_range(0, 1)));
      check_status("line_errs");
      send_vsync(1'b0);
      send_line(3, 1'b1);
      check_status("short_frame");
      clear_err();
      check_status("err_clr");

      // Error set and err_clr in the same cycle: the set wins.
      send_vsync(1'b1);
      check_status("set_wins");
      clear_err();

      // Complete frame 2 from the restart point, then frame 3.
      send_frame();
      check_status("frame2");
      send_vsync(1'b0);
      send_frame();
      check_status("frame3");

      // Reset mid-frame returns the display bank and count to 0.
      send_vsync(1'b0);
      send_line(H, 1'b1);
      send_line(H, 1'b0);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      m_active = 0; m_y = 0; m_disp = 0; m_frames = 0;
      m_long = 0; m_short = 0; m_sframe = 0;
      check_status("mid_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
